// File: rtl/ascon_tag_unit.sv
// ASCON-AEAD128 tag stage: captures tag from state words 3/4, streams it
// out (encrypt) or compares it against an expected tag (decrypt).
//
// Ports:
//   clock_i, reset_i                 rising-edge clock, sync active-high reset
//   state_i, capture_i, decrypt_i    finalised state, capture strobe, mode
//   exp_tag_i                        expected tag for decrypt compare
//   tag_word_o, tag_valid_o,
//   tag_ready_i                      MSB-first tag word stream
//   tag_ok_o, cmp_valid_o            compare result and its one-cycle strobe
//   busy_o, done_o                   activity flag and end-of-operation pulse

package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

module ascon_tag_unit
  import ascon_pack::*;
#(
  parameter int WORD_W    = 32,
  parameter bit CLEAR_TAG = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  type_state         state_i,
  input  logic              capture_i,
  input  logic              decrypt_i,
  input  logic [127:0]      exp_tag_i,
  output logic [WORD_W-1:0] tag_word_o,
  output logic              tag_valid_o,
  input  logic              tag_ready_i,
  output logic              tag_ok_o,
  output logic              cmp_valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NW = 128 / WORD_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CMP,
    DONE
  } state_t;

  state_t        st_q;
  state_t        st_d;
  logic [127:0]  tag_reg;
  logic [127:0]  exp_reg;
  logic [CW-1:0] cnt;
  logic [127:0]  tag_sh;
  logic          last;
  logic          xfer;
  logic          match;
  logic          start;

  // Words 0..2 of the state carry nothing the tag needs.
  logic unused_words;
  assign unused_words = ^{state_i[0], state_i[1], state_i[2]};

  assign start  = (st_q == IDLE) && capture_i;
  assign xfer   = (st_q == SEND) && tag_ready_i;
  assign last   = (cnt == CW'(NW - 1));
  assign tag_sh = tag_reg << (WORD_W * int'(cnt));

  // Full-width XOR/OR reduction: timing does not depend on the data.
  assign match = ~|(tag_reg ^ exp_reg);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (capture_i) begin
          st_d = decrypt_i ? CMP : SEND;
        end
      end
      SEND: begin
        if (tag_ready_i && last) begin
          st_d = DONE;
        end
      end
      CMP:  st_d = DONE;
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tag_reg <= '0;
      exp_reg <= '0;
      cnt     <= '0;
    end else begin
      if (start) begin
        tag_reg <= {state_i[3], state_i[4]};
        cnt     <= '0;
        if (decrypt_i) begin
          exp_reg <= exp_tag_i;
        end
      end
      if (xfer) begin
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (CLEAR_TAG && (st_q == DONE)) begin
        tag_reg <= '0;
        exp_reg <= '0;
      end
    end
  end

  always_comb begin
    tag_word_o  = '0;
    tag_valid_o = 1'b0;
    tag_ok_o    = 1'b0;
    cmp_valid_o = 1'b0;
    busy_o      = (st_q != IDLE);
    done_o      = 1'b0;
    unique case (st_q)
      SEND: begin
        tag_valid_o = 1'b1;
        tag_word_o  = tag_sh[127 -: WORD_W];
      end
      CMP: begin
        cmp_valid_o = 1'b1;
        tag_ok_o    = match;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
